mem_stage_lsu: RTL and testbench

- Load/store unit for the pipeline MEM stage; sits directly upstream of the word-wide data memory and drives its WE/A/WD while consuming its combinational RD.
- Turns byte-addressed RV32I loads/stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses.
- Implements sub-word stores as a two-cycle read-modify-write, because the memory has no byte enables.
- Registers load results and control into the MEM/WB boundary.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/mem_stage_lsu_if.sv | 43 ++++
 rtl/lsu_lane.sv | 44 ++++
 rtl/mem_stage_lsu.sv | 118 +++++++++++
 tb/tb_mem_stage_lsu.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM state type and access-check helpers for the MEM-stage LSU.
// Latency: none, declarations and pure functions only.
// Backpressure: not applicable.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE = 1'b0, MERGE = 1'b1} lsu_state_t;

  // funct3[1:0] encodes size for both loads and stores: 00 byte, 01 half, 10 word
  function automatic logic access_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

  function automatic logic load_f3_ok(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) || (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  function automatic logic store_f3_ok(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Bundle of EX/MEM inputs, data-memory port and MEM/WB outputs around the LSU.
// Latency: wires only.
// Backpressure: stall_o travels upstream inside this bundle.
interface mem_stage_lsu_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     valid_i;
  logic                     mem_read_i;
  logic                     mem_write_i;
  logic [2:0]               funct3_i;
  logic [ADDRESS_WIDTH-1:0] addr_i;
  logic [DATA_WIDTH-1:0]    wdata_i;
  logic [DATA_WIDTH-1:0]    alu_i;
  logic [4:0]               rd_i;
  logic                     reg_write_i;
  logic                     dm_we_o;
  logic [ADDRESS_WIDTH-1:0] dm_a_o;
  logic [DATA_WIDTH-1:0]    dm_wd_o;
  logic [DATA_WIDTH-1:0]    dm_rd_i;
  logic                     stall_o;
  logic                     wb_valid_o;
  logic [DATA_WIDTH-1:0]    wb_data_o;
  logic [4:0]               wb_rd_o;
  logic                     wb_reg_write_o;
  logic                     misalign_o;

  // pipeline + memory side
  modport master (
    output valid_i, mem_read_i, mem_write_i, funct3_i, addr_i, wdata_i, alu_i, rd_i,
           reg_write_i, dm_rd_i,
    input  dm_we_o, dm_a_o, dm_wd_o, stall_o, wb_valid_o, wb_data_o, wb_rd_o,
           wb_reg_write_o, misalign_o
  );

  // LSU side
  modport slave (
    input  valid_i, mem_read_i, mem_write_i, funct3_i, addr_i, wdata_i, alu_i, rd_i,
           reg_write_i, dm_rd_i,
    output dm_we_o, dm_a_o, dm_wd_o, stall_o, wb_valid_o, wb_data_o, wb_rd_o,
           wb_reg_write_o, misalign_o
  );
endinterface

// File: rtl/lsu_lane.sv
// Byte-lane logic: load lane extract/extend and sub-word store merge into the read word.
// Latency: purely combinational.
// Backpressure: none.
module lsu_lane
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            offset,
  input  logic [DATA_WIDTH-1:0] rd_word,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merge_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // pick the addressed lane and extend it to a full word for loads
  always_comb begin
    byte_sel  = rd_word[{offset, 3'b000} +: 8];
    half_sel  = offset[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = rd_word;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data = {24'h0, byte_sel};
      F3_LHU:  load_data = {16'h0, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // overwrite only the stored lane, keeping the other bytes of the current word
  always_comb begin
    merge_word = rd_word;
    if (funct3 == F3_SB) begin
      merge_word[{offset, 3'b000} +: 8] = wdata[7:0];
    end else if (funct3 == F3_SH) begin
      merge_word[{offset[1], 4'b0000} +: 16] = wdata[15:0];
    end
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: word-wide memory access, sub-word stores by read-modify-write.
// Latency: loads/ALU results 1 cycle to WB; SB/SH take 2 cycles (read+merge, then write).
// Backpressure: stall_o holds upstream for the read cycle of a SB/SH; WB gets bubbles meanwhile.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_lsu_if.slave bus
);

  lsu_state_t               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] merge_idx_q, in_idx;
  logic [DATA_WIDTH-1:0]    merge_word_q;
  logic [DATA_WIDTH-1:0]    load_data, merge_word;
  logic [1:0]               off;
  logic                     store_op, load_op, mis, sub_store, word_store, misalign_evt;
  logic                     we, stall;
  logic [ADDRESS_WIDTH-1:0] dm_a;
  logic [DATA_WIDTH-1:0]    dm_wd;

  assign off          = bus.addr_i[1:0];
  assign in_idx       = {2'b00, bus.addr_i[ADDRESS_WIDTH-1:2]};
  // store wins when both read and write are flagged
  assign store_op     = bus.valid_i & bus.mem_write_i;
  assign load_op      = bus.valid_i & bus.mem_read_i & ~bus.mem_write_i;
  assign mis          = access_misaligned(bus.funct3_i, off);
  assign sub_store    = store_op & ~mis & ((bus.funct3_i == F3_SB) | (bus.funct3_i == F3_SH));
  assign word_store   = store_op & ~mis & (bus.funct3_i == F3_SW);
  assign misalign_evt = mis & ((store_op & store_f3_ok(bus.funct3_i)) |
                               (load_op & load_f3_ok(bus.funct3_i)));

  lsu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .funct3     (bus.funct3_i),
    .offset     (off),
    .rd_word    (bus.dm_rd_i),
    .wdata      (bus.wdata_i),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a sub-word store enters MERGE for exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sub_store) state_d = MERGE;
      MERGE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; reset gates the write so an interrupted RMW never lands
  always_comb begin
    we    = 1'b0;
    stall = 1'b0;
    dm_a  = in_idx;
    dm_wd = bus.wdata_i;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          we    = word_store;
          stall = sub_store;
        end
        MERGE: begin
          we    = 1'b1;
          dm_a  = merge_idx_q;
          dm_wd = merge_word_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.dm_we_o = we;
  assign bus.dm_a_o  = dm_a;
  assign bus.dm_wd_o = dm_wd;
  assign bus.stall_o = stall;

  // capture merged word and its index during the read cycle of a sub-word store
  always_ff @(posedge clk) begin
    if (state_q == IDLE && sub_store) begin
      merge_word_q <= merge_word;
      merge_idx_q  <= in_idx;
    end
  end

  // MEM/WB register: bubble while stalled or completing a merge
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_valid_o     <= 1'b0;
      bus.wb_data_o      <= '0;
      bus.wb_rd_o        <= '0;
      bus.wb_reg_write_o <= 1'b0;
      bus.misalign_o     <= 1'b0;
    end else if (state_q == MERGE || stall) begin
      bus.wb_valid_o     <= 1'b0;
      bus.wb_reg_write_o <= 1'b0;
      bus.misalign_o     <= 1'b0;
    end else begin
      bus.wb_valid_o     <= bus.valid_i;
      bus.wb_data_o      <= load_op ? load_data : bus.alu_i;
      bus.wb_rd_o        <= bus.rd_i;
      bus.wb_reg_write_o <= bus.valid_i & bus.reg_write_i & ~bus.mem_write_i &
                            ~(load_op & (mis | ~load_f3_ok(bus.funct3_i)));
      bus.misalign_o     <= misalign_evt;
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a small word-wide memory model.
// Latency: checks combinational outputs mid-cycle and WB outputs one cycle later.
// Backpressure: follows stall_o by holding the instruction for the RMW cycle.
module tb_mem_stage_lsu;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] mem [0:63];

  mem_stage_lsu_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem_stage_lsu #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.dm_rd_i = mem[bus.dm_a_o[5:0]];

  always @(posedge clk) begin
    if (bus.dm_we_o) mem[bus.dm_a_o[5:0]] <= bus.dm_wd_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd, input logic [31:0] alu,
                       input logic [4:0] rdn, input logic rw);
    bus.valid_i     = v;
    bus.mem_read_i  = rd_en;
    bus.mem_write_i = wr_en;
    bus.funct3_i    = f3;
    bus.addr_i      = a;
    bus.wdata_i     = wd;
    bus.alu_i       = alu;
    bus.rd_i        = rdn;
    bus.reg_write_i = rw;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, 1'b1, F3_SW, a, d, 32'h0, 5'd0, 1'b0);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rdn);
    drive(1'b1, 1'b1, 1'b0, f3, a, 32'h0, 32'h0, rdn, 1'b1);
  endtask

  logic [31:0] se_addr [4] = '{32'h400A, 32'h400B, 32'h4008, 32'h400A};
  logic [2:0]  se_f3   [4] = '{F3_LB, F3_LBU, F3_LH, F3_LHU};
  logic [31:0] se_exp  [4] = '{32'hFFFFFFFF, 32'h00000080, 32'h00007F01, 32'h000080FF};

  initial begin
    nop();
    step();
    chk("rst_we", {31'h0, bus.dm_we_o}, 32'h0);
    chk("rst_stall", {31'h0, bus.stall_o}, 32'h0);
    step();
    rst = 1'b0;
    chk("rst_wb_valid", {31'h0, bus.wb_valid_o}, 32'h0);
    chk("rst_wb_rw", {31'h0, bus.wb_reg_write_o}, 32'h0);
    chk("rst_wb_data", bus.wb_data_o, 32'h0);
    chk("rst_misalign", {31'h0, bus.misalign_o}, 32'h0);

    // SW / LW round trip
    sw(32'h4000, 32'hDEADBEEF);
    #1;
    chk("sw_a", bus.dm_a_o, 32'h1000);
    chk("sw_we", {31'h0, bus.dm_we_o}, 32'h1);
    chk("sw_stall", {31'h0, bus.stall_o}, 32'h0);
    chk("sw_wd", bus.dm_wd_o, 32'hDEADBEEF);
    step();
    chk("sw_mem", mem[0], 32'hDEADBEEF);
    sw(32'h4004, 32'h11223344); step();
    sw(32'h4008, 32'h80FF7F01); step();
    sw(32'h400C, 32'hCAFEF00D); step();
    sw(32'h4010, 32'h01020304); step();
    ld(F3_LW, 32'h4000, 5'd5);
    #1;
    chk("lw_we", {31'h0, bus.dm_we_o}, 32'h0);
    step();
    chk("lw_data", bus.wb_data_o, 32'hDEADBEEF);
    chk("lw_valid", {31'h0, bus.wb_valid_o}, 32'h1);
    chk("lw_rw", {31'h0, bus.wb_reg_write_o}, 32'h1);
    chk("lw_rd", {27'h0, bus.wb_rd_o}, 32'd5);

    // SB read-modify-write
    drive(1'b1, 1'b0, 1'b1, F3_SB, 32'h4006, 32'h000000AA, 32'h0, 5'd0, 1'b0);
    #1;
    chk("sb_stall", {31'h0, bus.stall_o}, 32'h1);
    chk("sb_we0", {31'h0, bus.dm_we_o}, 32'h0);
    step();
    chk("sb_bubble1", {31'h0, bus.wb_valid_o}, 32'h0);
    chk("sb_we1", {31'h0, bus.dm_we_o}, 32'h1);
    chk("sb_wd", bus.dm_wd_o, 32'h11AA3344);
    chk("sb_a", bus.dm_a_o, 32'h1001);
    chk("sb_stall1", {31'h0, bus.stall_o}, 32'h0);
    step();
    chk("sb_mem", mem[1], 32'h11AA3344);
    chk("sb_bubble2", {31'h0, bus.wb_valid_o}, 32'h0);
    chk("sb_rw", {31'h0, bus.wb_reg_write_o}, 32'h0);

    // sign / zero extension
    for (int i = 0; i < 4; i++) begin
      ld(se_f3[i], se_addr[i], 5'd3);
      step();
      chk($sformatf("ext%0d", i), bus.wb_data_o, se_exp[i]);
    end

    // misalignment
    ld(F3_LW, 32'h4002, 5'd6);
    #1;
    chk("mis_lw_we", {31'h0, bus.dm_we_o}, 32'h0);
    step();
    chk("mis_lw_pulse", {31'h0, bus.misalign_o}, 32'h1);
    chk("mis_lw_rw", {31'h0, bus.wb_reg_write_o}, 32'h0);
    drive(1'b1, 1'b0, 1'b1, F3_SH, 32'h4001, 32'h00005555, 32'h0, 5'd0, 1'b0);
    #1;
    chk("mis_sh_we", {31'h0, bus.dm_we_o}, 32'h0);
    chk("mis_sh_stall", {31'h0, bus.stall_o}, 32'h0);
    step();
    chk("mis_sh_pulse", {31'h0, bus.misalign_o}, 32'h1);
    nop();
    step();
    chk("mis_pulse_end", {31'h0, bus.misalign_o}, 32'h0);
    chk("mis_mem", mem[0], 32'hDEADBEEF);

    // undefined funct3 load
    ld(3'b011, 32'h4000, 5'd4);
    step();
    chk("undef_rw", {31'h0, bus.wb_reg_write_o}, 32'h0);
    chk("undef_mis", {31'h0, bus.misalign_o}, 32'h0);

    // non-memory pass-through
    drive(1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h12345678, 5'd7, 1'b1);
    step();
    chk("alu_data", bus.wb_data_o, 32'h12345678);
    chk("alu_rd", {27'h0, bus.wb_rd_o}, 32'd7);
    chk("alu_rw", {31'h0, bus.wb_reg_write_o}, 32'h1);

    // reset during MERGE
    drive(1'b1, 1'b0, 1'b1, F3_SB, 32'h400C, 32'h00000077, 32'h0, 5'd0, 1'b0);
    step();
    rst = 1'b1;
    #1;
    chk("rstm_we", {31'h0, bus.dm_we_o}, 32'h0);
    step();
    rst = 1'b0;
    nop();
    #1;
    chk("rstm_mem", mem[3], 32'hCAFEF00D);
    chk("rstm_wb_valid", {31'h0, bus.wb_valid_o}, 32'h0);
    chk("rstm_wb_rw", {31'h0, bus.wb_reg_write_o}, 32'h0);
    chk("rstm_wb_data", bus.wb_data_o, 32'h0);
    chk("rstm_stall", {31'h0, bus.stall_o}, 32'h0);
    chk("rstm_we2", {31'h0, bus.dm_we_o}, 32'h0);
    drive(1'b1, 1'b0, 1'b1, F3_SB, 32'h400C, 32'h00000077, 32'h0, 5'd0, 1'b0);
    #1;
    chk("rstm_idle", {31'h0, bus.stall_o}, 32'h1);
    step();
    step();
    chk("rstm_redo", mem[3], 32'hCAFEF077);

    // SH then LW back-to-back
    drive(1'b1, 1'b0, 1'b1, F3_SH, 32'h4010, 32'h0000BEEF, 32'h0, 5'd0, 1'b0);
    #1;
    chk("b2b_stall", {31'h0, bus.stall_o}, 32'h1);
    step();
    chk("b2b_wd", bus.dm_wd_o, 32'h0102BEEF);
    step();
    ld(F3_LW, 32'h4010, 5'd9);
    step();
    chk("b2b_data", bus.wb_data_o, 32'h0102BEEF);
    chk("b2b_rd", {27'h0, bus.wb_rd_o}, 32'd9);
    nop();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
